uart_rx_top: RTL and testbench

Serial receiver counterpart of `uart_tx_top`: deserializes a burst of NUM_BYTES UART frames (8N1, LSB-first) from `rxd` and assembles them into one wide word. Byte 0 (first received) lands in `data_out[7:0]`, matching the transmitter's packing of `data_in`. It sits at the input pins of the design and feeds message-level consumers. It also serves as the loopback checker for the transmitter.

---
 rtl/uart_rx_top.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_top.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_top.sv
// uart_rx_top
// Receives a burst of NUM_BYTES UART frames (8N1, LSB first) on rxd and
// publishes them as one wide word. Byte 0 (first received) lands in
// data_out[7:0], byte i in data_out[8*i +: 8].
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 8)
//   NUM_BYTES     bytes per message
//   TIMEOUT_BITS  idle bit times before a partial message is dropped
//                 (only used when UART_RX_TIMEOUT_EN is defined)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rxd        serial input, idle high, asynchronous to clk
//   data_out   last complete message
//   valid      one-cycle pulse when data_out is updated
//   busy       high while a frame is in progress (FSM not in IDLE)
//   frame_err  one-cycle pulse on a bad stop bit
//   byte_cnt   bytes of the current message received so far
//
// Optional feature macro: UART_RX_TIMEOUT_EN enables the idle timeout that
// discards a partially received message.

module uart_rx_top #(
  parameter int CLKS_PER_BIT = 100,
  parameter int NUM_BYTES    = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rxd,
  output logic [8*NUM_BYTES-1:0]         data_out,
  output logic                           valid,
  output logic                           busy,
  output logic                           frame_err,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BC_W  = $clog2(NUM_BYTES+1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0]  LAST    = BC_W'(NUM_BYTES - 1);

  // Reject parameter sets the bit timing cannot support.
  if (CLKS_PER_BIT < 8 || TIMEOUT_BITS < 1) begin : g_bad_params
    $error("uart_rx_top: CLKS_PER_BIT must be >= 8 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                 state, state_next;
  logic                   rx_meta, rxs;
  logic [CNT_W-1:0]       bit_cnt;
  logic [2:0]             data_cnt;
  logic [7:0]             shift_reg;
  logic [8*NUM_BYTES-1:0] shadow, shadow_next;
  logic                   sample, store_byte, bad_stop, timeout_hit;

  assign busy = (state != IDLE);

  // Two-flop synchronizer; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. sample marks the mid-bit instant in each state;
  // after a good stop bit we go straight back to IDLE so a following start
  // edge right after a single stop bit is not missed.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    store_byte = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) state_next = START;
      end
      START: begin
        if (bit_cnt == HALF_M1) begin
          sample     = 1'b1;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == FULL_M1) begin
          sample = 1'b1;
          if (data_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == FULL_M1) begin
          sample = 1'b1;
          if (rxs) begin
            store_byte = 1'b1;
            state_next = IDLE;
          end else begin
            bad_stop   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow buffer with the current byte merged into its slot; used both
  // to update the shadow and to publish the full message in one cycle.
  always_comb begin
    shadow_next = shadow;
    shadow_next[8*byte_cnt +: 8] = shift_reg;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == IDLE) && rxs && (byte_cnt != '0) &&
                       (idle_cnt == IDLE_W'(IDLE_LIMIT - 1));

  // Counts consecutive idle cycles while a partial message is pending;
  // any start bit or leaving IDLE restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (state != IDLE || !rxs || byte_cnt == '0 || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Bit timing, deserializer and message assembly. Counters saturate at
  // their terminal values instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      data_cnt  <= '0;
      shift_reg <= '0;
      shadow    <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || sample)  bit_cnt <= '0;
      else if (bit_cnt != FULL_M1)  bit_cnt <= bit_cnt + 1'b1;

      if (state != DATA)                       data_cnt <= '0;
      else if (sample && data_cnt != 3'd7)     data_cnt <= data_cnt + 1'b1;

      if (state == DATA && sample) shift_reg <= {rxs, shift_reg[7:1]};

      if (bad_stop) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
      end else if (store_byte) begin
        shadow <= shadow_next;
        if (byte_cnt == LAST) begin
          data_out <= shadow_next;
          valid    <= 1'b1;
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top
// Directed bench for uart_rx_top with a short bit period. A frame table
// covers good and bad stop bits; hand-written sequences cover full
// messages, back-to-back frames, start glitches, mid-frame reset and the
// partial-message timeout (expectations follow UART_RX_TIMEOUT_EN).

module tb_uart_rx_top;

  localparam int CPB = 16;
  localparam int NB  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rxd = 1'b1;
  logic [127:0] data_out;
  logic         valid, busy, frame_err;
  logic [4:0]   byte_cnt;

  uart_rx_top #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .data_out(data_out),
    .valid(valid), .busy(busy), .frame_err(frame_err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int           check_cnt = 0;
  int           pass_cnt  = 0;
  int           valid_cnt = 0;
  int           ferr_cnt  = 0;
  logic         both_high = 1'b0;
  logic [127:0] last_data = '0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [4:0] exp_cnt;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      last_data = data_out;
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_high = 1'b1;
  end

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bits);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
    for (int k = 10; k < bits; k++) drive_bit(1'b1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    send_frame(v.data, v.stop, 11);
  endtask

  function automatic logic [127:0] make_msg(input logic [7:0] base);
    logic [127:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = base + 8'(i);
    return m;
  endfunction

  task automatic send_msg(input logic [7:0] base, input int bits);
    for (int i = 0; i < NB; i++) send_frame(base + 8'(i), 1'b1, bits);
  endtask

  initial begin
    int           v0, f0;
    logic         busy_seen;
    logic [127:0] mixed;

    vecs[0] = '{8'h41, 1'b1, 5'd1, 0};
    vecs[1] = '{8'h42, 1'b1, 5'd2, 0};
    vecs[2] = '{8'h43, 1'b1, 5'd3, 0};
    vecs[3] = '{8'h44, 1'b0, 5'd0, 1};
    vecs[4] = '{8'h5A, 1'b1, 5'd1, 0};
    vecs[5] = '{8'h00, 1'b1, 5'd2, 0};
    vecs[6] = '{8'hFF, 1'b1, 5'd3, 0};
    vecs[7] = '{8'h80, 1'b0, 5'd0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset data_out", data_out, '0);
    check_output("reset valid", {127'd0, valid}, '0);
    check_output("reset busy", {127'd0, busy}, '0);
    check_output("reset frame_err", {127'd0, frame_err}, '0);
    check_output("reset byte_cnt", {123'd0, byte_cnt}, '0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    // Full message with 11-bit spacing
    send_msg(8'h41, 11);
    check_output("msg1 valid count", 128'(valid_cnt), 128'd1);
    check_output("msg1 data", last_data, make_msg(8'h41));
    check_output("msg1 byte0", {120'd0, data_out[7:0]}, 128'h41);
    check_output("msg1 byte15", {120'd0, data_out[127:120]}, 128'h50);
    check_output("msg1 frame_err count", 128'(ferr_cnt), 128'd0);

    // Two messages back-to-back with a single stop bit
    send_msg(8'h41, 10);
    check_output("b2b first valid", 128'(valid_cnt), 128'd2);
    send_msg(8'h41, 10);
    repeat (CPB) @(negedge clk);
    check_output("b2b second valid", 128'(valid_cnt), 128'd3);
    check_output("b2b data", last_data, make_msg(8'h41));
    check_output("b2b byte_cnt", {123'd0, byte_cnt}, '0);

    // Short low glitch while idle
    v0 = valid_cnt; f0 = ferr_cnt; busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (5) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    rxd = 1'b1;
    repeat (30) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check_output("glitch entered START", {127'd0, busy_seen}, 128'd1);
    check_output("glitch busy after", {127'd0, busy}, '0);
    check_output("glitch byte_cnt", {123'd0, byte_cnt}, '0);
    check_output("glitch pulses", 128'(valid_cnt - v0 + ferr_cnt - f0), 128'd0);

    // Frame table: good frames and bad stop bits
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d byte_cnt", i), {123'd0, byte_cnt},
                   {123'd0, vecs[i].exp_cnt});
      check_output($sformatf("vec%0d frame_err", i), 128'(ferr_cnt - f0),
                   128'(vecs[i].exp_ferr));
      check_output($sformatf("vec%0d no valid", i), 128'(valid_cnt - v0), 128'd0);
    end
    check_output("data_out held after frame_err", data_out, make_msg(8'h41));

    // Full message after framing errors
    send_msg(8'h61, 11);
    check_output("post-ferr valid", 128'(valid_cnt), 128'd4);
    check_output("post-ferr data", data_out, make_msg(8'h61));

    // Reset during byte 7
    for (int i = 0; i < 7; i++) send_frame(8'hC0 + 8'(i), 1'b1, 11);
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_output("rst data_out", data_out, '0);
    check_output("rst byte_cnt", {123'd0, byte_cnt}, '0);
    check_output("rst busy", {127'd0, busy}, '0);
    check_output("rst valid", {127'd0, valid}, '0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    v0 = valid_cnt;
    send_msg(8'h10, 11);
    check_output("post-rst valid", 128'(valid_cnt - v0), 128'd1);
    check_output("post-rst data", data_out, make_msg(8'h10));

    // Partial message followed by a long idle gap
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) send_frame(8'hF0 + 8'(i), 1'b1, 11);
    repeat (25) drive_bit(1'b1);
`ifdef UART_RX_TIMEOUT_EN
    check_output("timeout byte_cnt", {123'd0, byte_cnt}, '0);
`else
    check_output("no-timeout byte_cnt", {123'd0, byte_cnt}, 128'd5);
`endif
    for (int i = 0; i < 11; i++) send_frame(8'h30 + 8'(i), 1'b1, 11);
    mixed = make_msg(8'h30) << 40;
    for (int i = 0; i < 5; i++) mixed[8*i +: 8] = 8'hF0 + 8'(i);
`ifdef UART_RX_TIMEOUT_EN
    check_output("timeout no early valid", 128'(valid_cnt - v0), 128'd0);
`else
    check_output("mixed valid", 128'(valid_cnt - v0), 128'd1);
    check_output("mixed data", data_out, mixed);
`endif
    for (int i = 11; i < 16; i++) send_frame(8'h30 + 8'(i), 1'b1, 11);
    check_output("gap total valid", 128'(valid_cnt - v0), 128'd1);
`ifdef UART_RX_TIMEOUT_EN
    check_output("timeout data", data_out, make_msg(8'h30));
    check_output("timeout end byte_cnt", {123'd0, byte_cnt}, '0);
`else
    check_output("no-timeout end byte_cnt", {123'd0, byte_cnt}, 128'd5);
`endif

    check_output("valid and frame_err overlap", {127'd0, both_high}, '0);
    check_output("total frame_err", 128'(ferr_cnt), 128'd2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
